// File: rtl/commit_halt_if.sv
// Retirement bus carrying up to COMMIT_W retiring instructions per cycle.
// Channel 0 is the oldest instruction in the bundle.
interface commit_halt_if #(
  parameter int XLEN     = 64,
  parameter int COMMIT_W = 2,
  parameter int AW       = 5
);
  logic [COMMIT_W-1:0]      cmt_valid;
  logic [COMMIT_W-1:0]      cmt_ebreak;
  logic [COMMIT_W-1:0]      cmt_wen;
  logic [COMMIT_W*AW-1:0]   cmt_waddr;
  logic [COMMIT_W*XLEN-1:0] cmt_wdata;
  logic [COMMIT_W*XLEN-1:0] cmt_pc;

  modport master (
    output cmt_valid, cmt_ebreak, cmt_wen, cmt_waddr, cmt_wdata, cmt_pc
  );
  modport slave (
    input cmt_valid, cmt_ebreak, cmt_wen, cmt_waddr, cmt_wdata, cmt_pc
  );
endinterface

// File: rtl/commit_halt_monitor.sv
// Retirement monitor: shadow GPR file, cycle/instret counters, ebreak and
// no-progress detection with a drained, sticky halt status.
module commit_halt_monitor #(
  parameter int XLEN     = 64,
  parameter int NR_GPR   = 32,
  parameter int COMMIT_W = 2,
  parameter int TIMEOUT  = 4096,
  parameter int DRAIN    = 2,
  localparam int AW      = $clog2(NR_GPR)
) (
  input  logic              clk,
  input  logic              rst_n,
  commit_halt_if.slave      cmt,
  input  logic [AW-1:0]     dbg_raddr,
  output logic [XLEN-1:0]   dbg_rdata,
  output logic              halt,
  output logic [1:0]        halt_code,
  output logic [XLEN-1:0]   halt_pc,
  output logic [63:0]       cycle_cnt,
  output logic [63:0]       instret_cnt
);

  localparam logic [AW-1:0] A0_IDX = AW'(10);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t            state_r;
  logic [31:0]       drain_cnt_r;
  logic [31:0]       idle_r;
  logic [XLEN-1:0]   last_pc_r;
  logic              halt_r;
  logic [1:0]        halt_code_r;
  logic [XLEN-1:0]   halt_pc_r;
  logic [63:0]       cycle_cnt_r;
  logic [63:0]       instret_cnt_r;
  logic [XLEN-1:0]   dbg_rdata_r;
  logic [XLEN-1:0]   gpr_r [NR_GPR];

  logic [COMMIT_W-1:0] eff_s;
  logic              blocked_s;
  logic              any_eff_s;
  logic              ebk_hit_s;
  logic [XLEN-1:0]   ebk_pc_s;
  logic [XLEN-1:0]   a0_fwd_s;
  logic [XLEN-1:0]   a0_at_ebk_s;
  logic [XLEN-1:0]   youngest_pc_s;
  logic [63:0]       ret_cnt_s;
  logic [31:0]       idle_next_s;
  logic              timeout_s;

  // Effective channels in age order; an ebreak masks every younger channel.
  always_comb begin
    eff_s         = '0;
    blocked_s     = 1'b0;
    ebk_hit_s     = 1'b0;
    ebk_pc_s      = '0;
    a0_fwd_s      = gpr_r[A0_IDX];
    a0_at_ebk_s   = gpr_r[A0_IDX];
    youngest_pc_s = last_pc_r;
    ret_cnt_s     = 64'd0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (cmt.cmt_valid[i] && (state_r == ST_RUN) && !blocked_s) begin
        eff_s[i]      = 1'b1;
        ret_cnt_s     = ret_cnt_s + 64'd1;
        youngest_pc_s = cmt.cmt_pc[i*XLEN +: XLEN];
        if (cmt.cmt_ebreak[i]) begin
          ebk_hit_s   = 1'b1;
          ebk_pc_s    = cmt.cmt_pc[i*XLEN +: XLEN];
          a0_at_ebk_s = a0_fwd_s;
          blocked_s   = 1'b1;
        end else if (cmt.cmt_wen[i] && (cmt.cmt_waddr[i*AW +: AW] == A0_IDX)) begin
          a0_fwd_s = cmt.cmt_wdata[i*XLEN +: XLEN];
        end else begin
          a0_fwd_s = a0_fwd_s;
        end
      end else begin
        eff_s[i] = 1'b0;
      end
    end
    any_eff_s   = |eff_s;
    idle_next_s = idle_r + 32'd1;
    if ((TIMEOUT > 0) && (state_r == ST_RUN) && !any_eff_s) begin
      timeout_s = (idle_next_s == 32'(TIMEOUT));
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Halt FSM together with its registered status and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      drain_cnt_r   <= 32'd0;
      idle_r        <= 32'd0;
      last_pc_r     <= '0;
      halt_r        <= 1'b0;
      halt_code_r   <= 2'b00;
      halt_pc_r     <= '0;
      cycle_cnt_r   <= 64'd0;
      instret_cnt_r <= 64'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          cycle_cnt_r   <= cycle_cnt_r + 64'd1;
          instret_cnt_r <= instret_cnt_r + ret_cnt_s;
          if (any_eff_s) begin
            idle_r    <= 32'd0;
            last_pc_r <= youngest_pc_s;
          end else begin
            idle_r <= idle_next_s;
          end
          if (ebk_hit_s || timeout_s) begin
            halt_code_r <= ebk_hit_s ? ((a0_at_ebk_s == '0) ? 2'b01 : 2'b10) : 2'b11;
            halt_pc_r   <= ebk_hit_s ? ebk_pc_s : last_pc_r;
            // A zero-length drain goes straight to DONE.
            if (DRAIN == 0) begin
              state_r <= ST_DONE;
              halt_r  <= 1'b1;
            end else begin
              state_r     <= ST_DRAIN;
              drain_cnt_r <= 32'(DRAIN);
            end
          end
        end
        ST_DRAIN: begin
          cycle_cnt_r <= cycle_cnt_r + 64'd1;
          if (drain_cnt_r <= 32'd1) begin
            state_r <= ST_DONE;
            halt_r  <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - 32'd1;
          end
        end
        ST_DONE: begin
          halt_r <= 1'b1;
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

  // Shadow register file and read-before-write debug port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NR_GPR; k++) begin
        gpr_r[k] <= '0;
      end
      dbg_rdata_r <= '0;
    end else begin
      dbg_rdata_r <= gpr_r[dbg_raddr];
      for (int i = 0; i < COMMIT_W; i++) begin
        if (eff_s[i] && cmt.cmt_wen[i] && !cmt.cmt_ebreak[i] &&
            (cmt.cmt_waddr[i*AW +: AW] != '0)) begin
          gpr_r[cmt.cmt_waddr[i*AW +: AW]] <= cmt.cmt_wdata[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign dbg_rdata   = dbg_rdata_r;
  assign halt        = halt_r;
  assign halt_code   = halt_code_r;
  assign halt_pc     = halt_pc_r;
  assign cycle_cnt   = cycle_cnt_r;
  assign instret_cnt = instret_cnt_r;

endmodule

// File: doc/commit_halt_monitor.md
Name: commit_halt_monitor

Overview:
Parametrised retirement monitor for the NPC simulation top. It watches up to COMMIT_W retiring instructions per cycle and keeps a shadow copy of the general-purpose register file, readable through a debug port. It detects ebreak (good/bad trap from a0) and no-progress timeouts, then drains and latches a sticky halt status. It also maintains cycle and retired-instruction counters. The harness polls `halt`/`halt_code` instead of relying on an immediate $finish.

Parameters:
XLEN, 64, register and PC width
NR_GPR, 32, number of GPRs shadowed (power of two); AW = $clog2(NR_GPR)
COMMIT_W, 2, commit channels per cycle; channel 0 is the oldest
TIMEOUT, 4096, consecutive cycles without a valid commit before timeout; 0 disables the watchdog
DRAIN, 2, cycles spent in DRAIN between halt detection and halt assertion

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmt_valid  in  COMMIT_W  per-channel retire valid
cmt_ebreak  in  COMMIT_W  per-channel: retiring instruction is ebreak
cmt_wen  in  COMMIT_W  per-channel GPR write enable
cmt_waddr  in  COMMIT_W*AW  per-channel destination register
cmt_wdata  in  COMMIT_W*XLEN  per-channel write data
cmt_pc  in  COMMIT_W*XLEN  per-channel PC
dbg_raddr  in  AW  shadow GPR read address
dbg_rdata  out  XLEN  shadow GPR read data, registered
halt  out  1  sticky halt flag
halt_code  out  2  00 running, 01 good trap, 10 bad trap, 11 timeout
halt_pc  out  XLEN  PC of the ebreak, or the last committed PC on timeout
cycle_cnt  out  64  cycles since reset
instret_cnt  out  64  retired instructions since reset

Behaviour:
- Reset (async, rst_n=0): all outputs 0, shadow GPRs 0, idle counter 0, FSM in RUN.
- Effective channels: channel i counts only if cmt_valid[i]=1, the FSM is in RUN, and no lower-index channel in the same cycle is a valid ebreak.
  - Channels after an ebreak in the same cycle are discarded entirely: no write, no count.
- Shadow GPR writes:
  - An effective channel with cmt_wen=1, waddr!=0 and ebreak=0 writes wdata at the clock edge.
  - x0 always reads 0.
  - If two channels write the same address in one cycle, the higher-index channel wins.
- dbg_rdata: 1-cycle latency; returns the array value before that same edge's writes (read-before-write).
- instret_cnt: increments by the popcount of effective channels (ebreak included); wraps at 2^64.
- cycle_cnt: increments every cycle in RUN and DRAIN; frozen in DONE; wraps.
- Idle counter:
  - Cleared on any cycle with at least one effective channel, otherwise increments in RUN.
  - Reaching TIMEOUT (TIMEOUT>0) triggers a timeout.
  - A last_pc register tracks the PC of the youngest effective channel.
- FSM RUN -> DRAIN -> DONE:
  - RUN, effective ebreak on channel i: latch halt_pc = cmt_pc[i]. Latch halt_code = 01 if a0 (x10) == 0, else 10.
    - The a0 value used includes same-cycle writes from channels < i (forwarded, highest such index wins).
    - Then enter DRAIN.
  - RUN, timeout: halt_code = 11, halt_pc = last_pc (0 if nothing has committed), enter DRAIN.
  - Ebreak and timeout in the same cycle cannot both fire, because an effective commit clears the idle counter; ebreak takes precedence by construction.
  - DRAIN: loads a counter with DRAIN and ignores all commits; when the counter expires, enter DONE.
    - DRAIN=0: DONE on the cycle after detection.
  - DONE: halt=1, sticky until reset. halt_code, halt_pc and the counters are frozen; dbg reads remain functional.
- halt_code and halt_pc become visible the cycle after detection; halt becomes visible DRAIN+1 cycles after detection.
- Reset asserted mid-DRAIN or in DONE returns everything to reset values immediately (async).

Test Plan:
1. Single write, then ebreak: ch0 writes x10=0 at cycle 5; ch0 ebreak pc=0x80000010 at cycle 8.
   -> halt=1 at cycle 8+DRAIN+1=11, halt_code=01, halt_pc=0x80000010, instret_cnt=2.
2. Same-cycle bad trap: ch0 writes x10=5 and ch1 is ebreak (pc=0x80000024) in the same cycle.
   -> halt_code=10, halt_pc=0x80000024, instret_cnt +2.
3. Ebreak on the older channel: ch0 ebreak, ch1 writes x3=0xdead in the same cycle.
   -> dbg read of x3 returns 0, instret_cnt +1.
4. Write collision: ch0 and ch1 both write x7 (0x11, 0x22); ch0 also writes x0=0xff in a later cycle.
   -> x7 reads 0x22, x0 reads 0, dbg_rdata valid one cycle after dbg_raddr.
5. Timeout: TIMEOUT=16; last commit pc=0x80000100, then cmt_valid=0.
   -> halt_code=11 after 16 idle cycles, halt_pc=0x80000100, halt at +DRAIN+1, cycle_cnt frozen thereafter.
6. Reset in DRAIN: rst_n=0 for 1 cycle while in DRAIN.
   -> halt, halt_code, halt_pc and the counters are 0 immediately; new commits are counted normally after release.
